// File: rtl/cpu16_pkg.sv
// Shared defaults and types for the cpu16 register file slice.
package cpu16_pkg;
    localparam int unsigned DATA_W_DEFAULT = 16;
    localparam int unsigned ADDR_W_DEFAULT = 3;

    typedef logic [ADDR_W_DEFAULT-1:0] regAddr_t;
endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-result scoreboard: one bit per register, set on issue, cleared on write,
// with a registered population count.
module regfile_scoreboard
    import cpu16_pkg::*;
#(
    parameter int unsigned ADDR_W   = ADDR_W_DEFAULT,
    parameter bit          ZERO_REG = 1'b1,
    parameter bit          BYPASS   = 1'b1
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              wrEn,
    input  logic [ADDR_W-1:0] wrAddr,
    input  logic              issueEn,
    input  logic [ADDR_W-1:0] issueAddr,
    input  logic [ADDR_W-1:0] rsAddr,
    input  logic [ADDR_W-1:0] rtAddr,
    output logic              rsBusy,
    output logic              rtBusy,
    output logic [ADDR_W:0]   pendingCount
);
    localparam int unsigned DEPTH = 1 << ADDR_W;
    localparam int unsigned CNT_W = ADDR_W + 1;

    logic [DEPTH-1:0] pending;
    logic [DEPTH-1:0] pendingNext;
    logic [CNT_W-1:0] countNext;

    // Clear is applied before set so a same-edge issue to the written register wins.
    always_comb begin
        pendingNext = pending;
        if (wrEn) begin
            pendingNext[wrAddr] = 1'b0;
        end
        if (issueEn) begin
            pendingNext[issueAddr] = 1'b1;
        end
        if (ZERO_REG) begin
            pendingNext[0] = 1'b0;
        end
        countNext = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            countNext = countNext + CNT_W'(pendingNext[i]);
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            pending      <= '0;
            pendingCount <= '0;
        end else begin
            pending      <= pendingNext;
            pendingCount <= countNext;
        end
    end

    always_comb begin
        rsBusy = pending[rsAddr];
        rtBusy = pending[rtAddr];
        if (BYPASS && wrEn && (wrAddr == rsAddr)) begin
            rsBusy = 1'b0;
        end
        if (BYPASS && wrEn && (wrAddr == rtAddr)) begin
            rtBusy = 1'b0;
        end
    end
endmodule

// File: rtl/regfile_mp.sv
// Two-read, one-write register file with optional zero register, write-to-read
// forwarding and a pending-result scoreboard.
module regfile_mp
    import cpu16_pkg::*;
#(
    parameter int unsigned DATA_W   = DATA_W_DEFAULT,
    parameter int unsigned ADDR_W   = ADDR_W_DEFAULT,
    parameter bit          ZERO_REG = 1'b1,
    parameter bit          BYPASS   = 1'b1
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] RS,
    input  logic [ADDR_W-1:0] RT,
    input  logic [ADDR_W-1:0] RD,
    input  logic [DATA_W-1:0] WriteData,
    input  logic              RegWrite,
    input  logic              IssueEn,
    input  logic [ADDR_W-1:0] IssueRd,
    output logic [DATA_W-1:0] ReadRS,
    output logic [DATA_W-1:0] ReadRT,
    output logic              RsBusy,
    output logic              RtBusy,
    output logic [ADDR_W:0]   PendingCount
);
    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] registers [DEPTH];
    logic              writeOk;

    assign writeOk = RegWrite && !(ZERO_REG && (RD == '0));

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                registers[i] <= '0;
            end
        end else if (writeOk) begin
            registers[RD] <= WriteData;
        end
    end

    always_comb begin
        ReadRS = registers[RS];
        ReadRT = registers[RT];
        if (BYPASS && writeOk && (RD == RS)) begin
            ReadRS = WriteData;
        end
        if (BYPASS && writeOk && (RD == RT)) begin
            ReadRT = WriteData;
        end
        if (ZERO_REG && (RS == '0)) begin
            ReadRS = '0;
        end
        if (ZERO_REG && (RT == '0)) begin
            ReadRT = '0;
        end
    end

    regfile_scoreboard #(
        .ADDR_W  (ADDR_W),
        .ZERO_REG(ZERO_REG),
        .BYPASS  (BYPASS)
    ) u_scoreboard (
        .clock       (clock),
        .reset_n     (reset_n),
        .wrEn        (RegWrite),
        .wrAddr      (RD),
        .issueEn     (IssueEn),
        .issueAddr   (IssueRd),
        .rsAddr      (RS),
        .rtAddr      (RT),
        .rsBusy      (RsBusy),
        .rtBusy      (RtBusy),
        .pendingCount(PendingCount)
    );
endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: default build, a no-bypass build and a 32x16 build.
module tb_regfile_mp;
    logic clock = 1'b0;
    logic reset_n;
    int   checks = 0;
    int   errors = 0;

    always #5 clock = ~clock;

    // default instance (16-bit, 8 regs, zero reg, bypass)
    logic [2:0]  rs, rt, rd, ird;
    logic [15:0] wd, readA, readB;
    logic        we, ie, rsBusy, rtBusy;
    logic [3:0]  cnt;

    // no-bypass instance
    logic [2:0]  nRs, nRt, nRd, nIrd;
    logic [15:0] nWd, nReadA, nReadB;
    logic        nWe, nIe, nRsBusy, nRtBusy;
    logic [3:0]  nCnt;

    // wide instance (32-bit, 16 regs)
    logic [3:0]  wRs, wRt, wRd, wIrd;
    logic [31:0] wWd, wReadA, wReadB;
    logic        wWe, wIe, wRsBusy, wRtBusy;
    logic [4:0]  wCnt;

    regfile_mp dut (
        .clock(clock), .reset_n(reset_n), .RS(rs), .RT(rt), .RD(rd),
        .WriteData(wd), .RegWrite(we), .IssueEn(ie), .IssueRd(ird),
        .ReadRS(readA), .ReadRT(readB), .RsBusy(rsBusy), .RtBusy(rtBusy),
        .PendingCount(cnt)
    );

    regfile_mp #(.BYPASS(1'b0)) dutNb (
        .clock(clock), .reset_n(reset_n), .RS(nRs), .RT(nRt), .RD(nRd),
        .WriteData(nWd), .RegWrite(nWe), .IssueEn(nIe), .IssueRd(nIrd),
        .ReadRS(nReadA), .ReadRT(nReadB), .RsBusy(nRsBusy), .RtBusy(nRtBusy),
        .PendingCount(nCnt)
    );

    regfile_mp #(.DATA_W(32), .ADDR_W(4)) dutWide (
        .clock(clock), .reset_n(reset_n), .RS(wRs), .RT(wRt), .RD(wRd),
        .WriteData(wWd), .RegWrite(wWe), .IssueEn(wIe), .IssueRd(wIrd),
        .ReadRS(wReadA), .ReadRT(wReadB), .RsBusy(wRsBusy), .RtBusy(wRtBusy),
        .PendingCount(wCnt)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        we = 0; ie = 0; rd = 0; ird = 0; wd = '0; rs = 0; rt = 0;
        nWe = 0; nIe = 0; nRd = 0; nIrd = 0; nWd = '0; nRs = 0; nRt = 0;
        wWe = 0; wIe = 0; wRd = 0; wIrd = 0; wWd = '0; wRs = 0; wRt = 0;
    endtask

    task automatic test_reset();
        rs = 3'd5; #1;
        checks++; if (readA !== 16'h0000) begin errors++; $display("FAIL reset_reg5: got %h expected %h", readA, 16'h0000); end
        checks++; if (cnt !== 4'd0) begin errors++; $display("FAIL reset_count: got %0d expected %0d", cnt, 0); end
        we = 1; rd = 3'd5; wd = 16'hBEEF; tick();
        we = 0; #1;
        checks++; if (readA !== 16'hBEEF) begin errors++; $display("FAIL write_r5: got %h expected %h", readA, 16'hBEEF); end
        ie = 1; ird = 3'd3; tick();
        ie = 0; #1;
        checks++; if (cnt !== 4'd1) begin errors++; $display("FAIL issue_r3_count: got %0d expected %0d", cnt, 1); end
        // reset must beat a concurrent write and issue
        reset_n = 0; we = 1; rd = 3'd5; wd = 16'h1111; ie = 1; ird = 3'd2; tick();
        reset_n = 1; we = 0; ie = 0; rs = 3'd5; rt = 3'd3; #1;
        checks++; if (readA !== 16'h0000) begin errors++; $display("FAIL reset_clears_r5: got %h expected %h", readA, 16'h0000); end
        checks++; if (cnt !== 4'd0) begin errors++; $display("FAIL reset_clears_count: got %0d expected %0d", cnt, 0); end
        checks++; if (rtBusy !== 1'b0) begin errors++; $display("FAIL reset_clears_pending: got %b expected %b", rtBusy, 1'b0); end
        rs = 3'd2; #1;
        checks++; if (rsBusy !== 1'b0) begin errors++; $display("FAIL reset_beats_issue: got %b expected %b", rsBusy, 1'b0); end
    endtask

    task automatic test_zero_reg();
        we = 1; rd = 3'd0; wd = 16'h1234; rs = 3'd0; rt = 3'd0; ie = 1; ird = 3'd0; #1;
        checks++; if (readA !== 16'h0000) begin errors++; $display("FAIL zero_rs_before: got %h expected %h", readA, 16'h0000); end
        checks++; if (readB !== 16'h0000) begin errors++; $display("FAIL zero_rt_before: got %h expected %h", readB, 16'h0000); end
        tick();
        we = 0; ie = 0; #1;
        checks++; if (readA !== 16'h0000) begin errors++; $display("FAIL zero_rs_after: got %h expected %h", readA, 16'h0000); end
        checks++; if (cnt !== 4'd0) begin errors++; $display("FAIL zero_pending_count: got %0d expected %0d", cnt, 0); end
        checks++; if (rsBusy !== 1'b0) begin errors++; $display("FAIL zero_busy: got %b expected %b", rsBusy, 1'b0); end
    endtask

    task automatic test_bypass();
        we = 1; rd = 3'd3; wd = 16'h0011; nWe = 1; nRd = 3'd3; nWd = 16'h0011; tick();
        wd = 16'hA5A5; nWd = 16'hA5A5; rs = 3'd3; rt = 3'd3; nRs = 3'd3; nRt = 3'd3; #1;
        checks++; if (readA !== 16'hA5A5) begin errors++; $display("FAIL bypass_rs: got %h expected %h", readA, 16'hA5A5); end
        checks++; if (readB !== 16'hA5A5) begin errors++; $display("FAIL bypass_rt: got %h expected %h", readB, 16'hA5A5); end
        checks++; if (nReadA !== 16'h0011) begin errors++; $display("FAIL nobypass_rs: got %h expected %h", nReadA, 16'h0011); end
        checks++; if (nReadB !== 16'h0011) begin errors++; $display("FAIL nobypass_rt: got %h expected %h", nReadB, 16'h0011); end
        rt = 3'd5; #1;
        checks++; if (readB !== 16'h0000) begin errors++; $display("FAIL bypass_other_port: got %h expected %h", readB, 16'h0000); end
        tick();
        we = 0; nWe = 0; #1;
        checks++; if (readA !== 16'hA5A5) begin errors++; $display("FAIL bypass_stored: got %h expected %h", readA, 16'hA5A5); end
        checks++; if (nReadA !== 16'hA5A5) begin errors++; $display("FAIL nobypass_stored: got %h expected %h", nReadA, 16'hA5A5); end
    endtask

    task automatic test_scoreboard();
        ie = 1; ird = 3'd2; tick();
        ird = 3'd4; tick();
        ie = 0; rs = 3'd2; rt = 3'd4; #1;
        checks++; if (cnt !== 4'd2) begin errors++; $display("FAIL sb_count2: got %0d expected %0d", cnt, 2); end
        checks++; if (rsBusy !== 1'b1) begin errors++; $display("FAIL sb_rs_busy: got %b expected %b", rsBusy, 1'b1); end
        checks++; if (rtBusy !== 1'b1) begin errors++; $display("FAIL sb_rt_busy: got %b expected %b", rtBusy, 1'b1); end
        we = 1; rd = 3'd2; wd = 16'h2222; #1;
        checks++; if (rsBusy !== 1'b0) begin errors++; $display("FAIL sb_busy_bypass: got %b expected %b", rsBusy, 1'b0); end
        checks++; if (rtBusy !== 1'b1) begin errors++; $display("FAIL sb_busy_other: got %b expected %b", rtBusy, 1'b1); end
        tick();
        we = 0; #1;
        checks++; if (rsBusy !== 1'b0) begin errors++; $display("FAIL sb_cleared: got %b expected %b", rsBusy, 1'b0); end
        checks++; if (cnt !== 4'd1) begin errors++; $display("FAIL sb_count1: got %0d expected %0d", cnt, 1); end
        checks++; if (readA !== 16'h2222) begin errors++; $display("FAIL sb_write_data: got %h expected %h", readA, 16'h2222); end
        nIe = 1; nIrd = 3'd1; tick();
        nIe = 0; nWe = 1; nRd = 3'd1; nWd = 16'h0101; nRs = 3'd1; #1;
        checks++; if (nRsBusy !== 1'b1) begin errors++; $display("FAIL nb_busy_stored: got %b expected %b", nRsBusy, 1'b1); end
        tick();
        nWe = 0; #1;
        checks++; if (nRsBusy !== 1'b0) begin errors++; $display("FAIL nb_busy_cleared: got %b expected %b", nRsBusy, 1'b0); end
        checks++; if (nCnt !== 4'd0) begin errors++; $display("FAIL nb_count: got %0d expected %0d", nCnt, 0); end
    endtask

    task automatic test_collision();
        ie = 1; ird = 3'd6; tick();
        ie = 0; #1;
        checks++; if (cnt !== 4'd2) begin errors++; $display("FAIL col_pre_count: got %0d expected %0d", cnt, 2); end
        ie = 1; ird = 3'd6; we = 1; rd = 3'd6; wd = 16'h6666; tick();
        ie = 0; we = 0; rs = 3'd6; #1;
        checks++; if (readA !== 16'h6666) begin errors++; $display("FAIL col_data: got %h expected %h", readA, 16'h6666); end
        checks++; if (rsBusy !== 1'b1) begin errors++; $display("FAIL col_pending: got %b expected %b", rsBusy, 1'b1); end
        checks++; if (cnt !== 4'd2) begin errors++; $display("FAIL col_count: got %0d expected %0d", cnt, 2); end
        ie = 1; ird = 3'd4; tick();
        ie = 0; #1;
        checks++; if (cnt !== 4'd2) begin errors++; $display("FAIL reissue_count: got %0d expected %0d", cnt, 2); end
        // set R7 and clear R4 on the same edge
        ie = 1; ird = 3'd7; we = 1; rd = 3'd4; wd = 16'h4444; tick();
        ie = 0; we = 0; rs = 3'd7; rt = 3'd4; #1;
        checks++; if (cnt !== 4'd2) begin errors++; $display("FAIL setclr_count: got %0d expected %0d", cnt, 2); end
        checks++; if (rsBusy !== 1'b1) begin errors++; $display("FAIL setclr_r7: got %b expected %b", rsBusy, 1'b1); end
        checks++; if (rtBusy !== 1'b0) begin errors++; $display("FAIL setclr_r4: got %b expected %b", rtBusy, 1'b0); end
    endtask

    task automatic test_sweep();
        wIe = 1; wIrd = 4'd0; tick();
        wIe = 0; #1;
        checks++; if (wCnt !== 5'd0) begin errors++; $display("FAIL wide_zero_issue: got %0d expected %0d", wCnt, 0); end
        for (int i = 1; i < 16; i++) begin
            wIe = 1; wIrd = 4'(i); tick();
        end
        wIe = 0; #1;
        checks++; if (wCnt !== 5'd15) begin errors++; $display("FAIL wide_count15: got %0d expected %0d", wCnt, 15); end
        for (int i = 1; i < 16; i++) begin
            wWe = 1; wRd = 4'(i); wWd = {4{4'(i), 4'(i)}}; tick();
        end
        wWe = 0; wRs = 4'd15; wRt = 4'd9; #1;
        checks++; if (wCnt !== 5'd0) begin errors++; $display("FAIL wide_count0: got %0d expected %0d", wCnt, 0); end
        checks++; if (wReadA !== 32'hFFFF_FFFF) begin errors++; $display("FAIL wide_r15: got %h expected %h", wReadA, 32'hFFFF_FFFF); end
        checks++; if (wReadB !== 32'h9999_9999) begin errors++; $display("FAIL wide_r9: got %h expected %h", wReadB, 32'h9999_9999); end
    endtask

    initial begin
        idle();
        reset_n = 0;
        tick();
        tick();
        reset_n = 1;
        test_reset();
        test_zero_reg();
        test_bypass();
        test_scoreboard();
        test_collision();
        test_sweep();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 Parameter DATA_W, default 16: register width in bits.
REQ-002 Parameter ADDR_W, default 3: register address width; DEPTH = 2**ADDR_W.
REQ-003 Parameter ZERO_REG, default 1: 1 = register 0 reads as zero and ignores writes; 0 = register 0 is an ordinary register.
REQ-004 Parameter BYPASS, default 1: 1 = same-cycle write data forwards to the read ports; 0 = reads return the stored value only.
REQ-005 clock  in  1  single clock; all state updates on its rising edge.
REQ-006 reset_n  in  1  reset; synchronous, active-low.
REQ-007 RS  in  ADDR_W  read port A address.
REQ-008 RT  in  ADDR_W  read port B address.
REQ-009 RD  in  ADDR_W  write address.
REQ-010 WriteData  in  DATA_W  write data.
REQ-011 RegWrite  in  1  write enable; RD and WriteData are used only when it is 1.
REQ-012 IssueEn  in  1  marks register IssueRd pending, i.e. a result is outstanding.
REQ-013 IssueRd  in  ADDR_W  register to mark pending.
REQ-014 ReadRS  out  DATA_W  combinational read data, port A.
REQ-015 ReadRT  out  DATA_W  combinational read data, port B.
REQ-016 RsBusy  out  1  combinational; pending bit of RS, bypass-adjusted.
REQ-017 RtBusy  out  1  combinational; pending bit of RT, bypass-adjusted.
REQ-018 PendingCount  out  ADDR_W+1  registered count of pending registers.

Function
REQ-019 Write: on a rising edge with RegWrite=1, Registers[RD] SHALL become WriteData; with RegWrite=0 no register changes.
REQ-020 Zero register: with ZERO_REG=1, a write to RD=0 SHALL be dropped, and ReadRS/ReadRT SHALL return 0 for address 0.
REQ-021 Bypass data: with BYPASS=1 and RegWrite=1, a read address equal to RD (and not the zero register) SHALL return WriteData in the same cycle.
REQ-022 Port independence: both read ports SHALL be fully independent, including RS=RT.
REQ-023 Pending clear: on each edge, a write to RD SHALL clear pending[RD].
REQ-024 Pending set: IssueEn=1 SHALL set pending[IssueRd].
REQ-025 Same register, same edge: set SHALL win over clear; net state is pending=1.
REQ-026 Zero register pending: with ZERO_REG=1, pending[0] SHALL remain 0 at all times.
REQ-027 Busy bypass: with BYPASS=1, RsBusy SHALL read 0 when RegWrite=1 and RD=RS; same rule for RtBusy with RT.
REQ-028 Busy without bypass: with BYPASS=0, RsBusy/RtBusy SHALL show the stored pending bit only.
REQ-029 PendingCount SHALL equal the population count of the pending bits after each edge (one-cycle latency) and SHALL never exceed DEPTH.
REQ-030 Re-issue: IssueEn on an already-pending register SHALL be idempotent; the count is unchanged.

Reset
REQ-031 Reset action: on a rising edge with reset_n=0, all DEPTH registers SHALL become 0, all pending bits 0, and PendingCount 0.
REQ-032 Priority: reset SHALL override RegWrite and IssueEn in the same cycle.
REQ-033 Outputs during reset: while reset_n=0, combinational outputs still follow the address inputs; after the first reset edge they read 0, except for bypass.
REQ-034 Reset mid-operation SHALL discard outstanding pending state; no partial state survives.

Structure
REQ-035 Shared package cpu16_pkg SHALL hold the DATA_W and ADDR_W defaults and the register-address typedef.
REQ-036 The pending bits, set/clear logic and PendingCount SHALL sit in one sub-module, regfile_scoreboard; the storage array and read muxes stay in regfile_mp.
REQ-037 Storage SHALL be a flat register array; no memory macros and no initial blocks are used for reset.

Verification
REQ-038 Reset: write 0xBEEF to R5, then hold reset_n=0 for one edge -> ReadRS(RS=5)=0x0000 and PendingCount=0.
REQ-039 Zero register: RegWrite=1, RD=0, WriteData=0x1234 -> ReadRS(RS=0)=0x0000 before and after the edge (ZERO_REG=1).
REQ-040 Bypass: R3 holds 0x0011; RegWrite=1, RD=3, WriteData=0xA5A5, RS=RT=3 -> both ports read 0xA5A5 in the same cycle; with BYPASS=0 they read 0x0011 until the edge.
REQ-041 Scoreboard: IssueEn on R2, then on R4 -> PendingCount=2 and RsBusy(RS=2)=1; write R2 -> RsBusy=0 after the edge and PendingCount=1.
REQ-042 Collision: IssueEn with IssueRd=6 and RegWrite with RD=6 on the same edge, R6 previously pending -> R6 holds the new data, pending[6]=1, count unchanged.
REQ-043 Parameter sweep: DATA_W=32, ADDR_W=4, issue all 15 non-zero registers -> PendingCount=15; then write all -> 0.
